ccd_edge_reader: RTL and testbench
==================================

Name: ccd_edge_reader

Overview:
Parametrised successor to the single-channel CCD line reader. It frames each CCD line from the shift-gate pulse and pixel strobe, and samples the thresholded video bit once per pixel. A run-length glitch filter rejects short transitions, and every filtered rising or falling edge is reported as a {polarity, pixel index} record. Records are buffered in a FIFO drained over a valid/ready handshake, and per-line status (line done, edge count, overflow) goes to the downstream position-processing logic.

Parameters:
PIX_W, 11, width of the pixel index and of the pixel counter
NUM_PIX, 2048, pixels per line (must be 2..2**PIX_W)
MIN_RUN, 2, consecutive equal samples needed to accept a level change (1 = no filtering)
FIFO_DEPTH, 8, edge records buffered (power of two, >=2)
CNT_W, 6, width of the per-line edge counter (saturating)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
en  in  1  block enable; low forces IDLE and flushes the FIFO
sh_pulse  in  1  shift-gate pulse (asynchronous); its rising edge starts a line
ccd_pulse  in  1  pixel strobe (asynchronous, may last several clk); one pixel per rising edge
data_in  in  1  thresholded video bit (asynchronous)
edge_pos  out  PIX_W  pixel index of the buffered edge at the FIFO head
edge_pol  out  1  1 = rising (0->1), 0 = falling
edge_valid  out  1  FIFO head is valid
edge_ready  in  1  consumer accepts the head when edge_valid & edge_ready
line_done  out  1  one-clk pulse after pixel NUM_PIX-1 of a complete line
line_edges  out  CNT_W  edges detected in the last completed line (saturates at all-ones)
overflow  out  1  sticky: an edge was dropped because the FIFO was full

Behaviour:
- Reset values: edge_valid=0, edge_pos=0, edge_pol=0, line_done=0, line_edges=0, overflow=0; FIFO empty; state IDLE.
- Synchronisers: sh_pulse, ccd_pulse and data_in each pass through 2 flops. Rising-edge detection on synced sh_pulse and ccd_pulse uses a third flop. Levels held high produce exactly one event.
- FSM IDLE -> ARMED when en=1. ARMED -> LINE on sh rise; pix_cnt=0, filtered level unknown. LINE -> ARMED after the ccd rise that samples pixel NUM_PIX-1; line_done pulses on the next clk and line_edges updates in the same clk. Any state -> IDLE when en=0.
- Sampling: on each ccd rise in LINE, take synced data_in as the sample for pixel pix_cnt, then increment pix_cnt. ccd rises in IDLE/ARMED are ignored.
- Filter: the pixel-0 sample sets the filtered level (no edge at pixel 0). A candidate starts when a sample differs from the filtered level. It is accepted after MIN_RUN consecutive differing samples. A sample equal to the filtered level cancels the candidate.
- Edge record: pos = index of the first pixel of the accepted run; pol = new level. The record is pushed in the clk after the accepting ccd rise. A candidate still unconfirmed at end of line is discarded.
- sh rise during LINE aborts the current line: no line_done, line_edges unchanged, pix_cnt=0, filter reinitialised. FIFO contents are kept.
- FIFO: show-ahead. edge_valid rises 1 clk after a push into an empty FIFO. The head is held stable while edge_valid & !edge_ready. On push when full with no pop, the record is dropped, overflow=1 and line_edges still counts it. On full with simultaneous pop, the push is accepted.
- overflow clears only on rst or en=0. en=0 empties the FIFO in 1 clk and drives edge_valid=0.
- Reset mid-line: all state returns to reset values asynchronously; there is no partial output.

Decomposition:
- Package ccd_pkg: FSM state enum (IDLE, ARMED, LINE) and the edge-record width constant (PIX_W+1), plus pack/unpack of the edge record.
- Sub-module ccd_edge_fifo: parametrised depth/width synchronous FIFO with valid/ready output, flush and full/empty flags. The top level holds the synchronisers, FSM, counter and filter.

Test Plan:
- NUM_PIX=16, MIN_RUN=2; sh pulse; data_in low for pixels 0-4, high from 5 -> one record pol=1 pos=5; line_done after pixel 15; line_edges=1.
- 1-pixel high glitch at pixel 7, otherwise low -> no record; line_edges=0. Same stimulus with MIN_RUN=1 -> records (1,7) and (0,8).
- High at pixels 0-3, low after -> pixel 0 gives no edge; one record pol=0 pos=4.
- edge_ready=0, 10 alternating 2-pixel runs with FIFO_DEPTH=8 -> 8 records held, overflow=1, line_edges=10; then edge_ready=1 drains pos order 2,4,...,16-equivalent, with the head stable while stalled.
- sh pulse again at pixel 9 -> no line_done for the aborted line; the new line counts from 0 and edge positions are relative to the new sh.
- en drops mid-line with the FIFO non-empty -> edge_valid=0 next clk, overflow=0, state IDLE; assert rst mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/ccd_pkg.sv
// Shared types and helpers for the CCD edge reader.
//   ccd_state_e : line-framing FSM states
//   edge_rec_w  : edge record width for a given pixel-index width ({pol, pos})
//   edge_pack / edge_pol_of / edge_pos_of : record (un)packing on a max-width container
package ccd_pkg;

  typedef enum logic [1:0] {StIdle, StArmed, StLine} ccd_state_e;

  localparam int unsigned EdgePolW    = 1;
  localparam int unsigned EdgeMaxPixW = 32;

  // Container wide enough for any supported PIX_W; callers size-cast to their record width.
  typedef logic [EdgeMaxPixW:0]   edge_rec_t;
  typedef logic [EdgeMaxPixW-1:0] edge_pos_t;

  function automatic int unsigned edge_rec_w(input int unsigned pix_w);
    return pix_w + EdgePolW;
  endfunction

  // pos must already be zero above bit pix_w-1.
  function automatic edge_rec_t edge_pack(input logic pol, input edge_pos_t pos,
                                          input int unsigned pix_w);
    return {1'b0, pos} | (edge_rec_t'(pol) << pix_w);
  endfunction

  function automatic logic edge_pol_of(input edge_rec_t rec, input int unsigned pix_w);
    return |((rec >> pix_w) & edge_rec_t'(1));
  endfunction

  function automatic edge_pos_t edge_pos_of(input edge_rec_t rec, input int unsigned pix_w);
    return rec[EdgeMaxPixW-1:0] & ~({EdgeMaxPixW{1'b1}} << pix_w);
  endfunction

endpackage

// File: rtl/ccd_edge_fifo.sv
// Show-ahead synchronous FIFO for edge records.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : synchronous empty (pointers and count cleared)
//   push, push_data : write request; accepted if not full or if a pop happens in the same clk
//   dropped       : push rejected because full with no pop
//   out_valid, out_ready, out_data : head of queue with valid/ready handshake
//   full, empty   : occupancy flags
module ccd_edge_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  output logic             dropped,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   count_q;
  logic             pop, push_ok;

  assign full      = (count_q == (AddrW+1)'(Depth));
  assign empty     = (count_q == '0);
  assign pop       = !empty && out_ready;
  assign push_ok   = push && (!full || pop);
  assign dropped   = push && full && !pop;
  assign out_valid = !empty;
  assign out_data  = mem_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AddrW'(1);
      if (pop)     rptr_q <= rptr_q + AddrW'(1);
      count_q <= count_q + (AddrW+1)'(push_ok) - (AddrW+1)'(pop);
    end
  end

  // Storage needs no reset: out_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/ccd_edge_reader.sv
// CCD line reader with glitch-filtered edge detection.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : block enable; low forces idle, flushes the FIFO and clears overflow
//   sh_pulse, ccd_pulse, data_in : asynchronous line start, pixel strobe and video bit
//   edge_pos, edge_pol, edge_valid, edge_ready : FIFO head of {polarity, pixel index} records
//   line_done  : one-clk pulse after the last pixel of a complete line
//   line_edges : saturating edge count of the last completed line
//   overflow   : sticky, a record was dropped on a full FIFO
module ccd_edge_reader
  import ccd_pkg::*;
#(
  parameter int unsigned PIX_W      = 11,
  parameter int unsigned NUM_PIX    = 2048,
  parameter int unsigned MIN_RUN    = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sh_pulse,
  input  logic             ccd_pulse,
  input  logic             data_in,
  output logic [PIX_W-1:0] edge_pos,
  output logic             edge_pol,
  output logic             edge_valid,
  input  logic             edge_ready,
  output logic             line_done,
  output logic [CNT_W-1:0] line_edges,
  output logic             overflow
);

  localparam int unsigned      RecW      = edge_rec_w(PIX_W);
  localparam int unsigned      RunW      = $clog2(MIN_RUN + 1);
  localparam logic [PIX_W-1:0] LastPix   = PIX_W'(NUM_PIX - 1);
  localparam logic [RunW-1:0]  RunAccept = RunW'(MIN_RUN);

  // Synchronisers; the third stage of sh/ccd is the edge-detect history.
  logic [2:0] sh_sr, ccd_sr;
  logic [1:0] data_sr;
  logic       sh_rise, ccd_rise, sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_sr   <= '0;
      ccd_sr  <= '0;
      data_sr <= '0;
    end else begin
      sh_sr   <= {sh_sr[1:0], sh_pulse};
      ccd_sr  <= {ccd_sr[1:0], ccd_pulse};
      data_sr <= {data_sr[0], data_in};
    end
  end

  assign sh_rise  = sh_sr[1] & ~sh_sr[2];
  assign ccd_rise = ccd_sr[1] & ~ccd_sr[2];
  assign sample   = data_sr[1];

  // Line-framing FSM
  ccd_state_e state_q, state_d;
  logic [PIX_W-1:0] pix_cnt_q;
  logic line_start, pix_take, last_pix;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StArmed;
      StArmed: if (sh_rise) state_d = StLine;
      StLine:  if (last_pix) state_d = StArmed;
      default: state_d = StIdle;
    endcase
    if (!en) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // sh rise wins over a coincident ccd rise: it restarts (or aborts) the line.
  assign line_start = en && sh_rise && (state_q == StArmed || state_q == StLine);
  assign pix_take   = en && !sh_rise && ccd_rise && (state_q == StLine);
  assign last_pix   = pix_take && (pix_cnt_q == LastPix);

  // Run-length filter
  logic             level_q;
  logic [RunW-1:0]  run_q, run_inc;
  logic [PIX_W-1:0] cand_pos_q, acc_pos;
  logic [CNT_W-1:0] line_cnt_q, cnt_next, line_edges_q;
  logic             first_pix, differ, accept;
  logic             push_q, line_done_q, overflow_q;
  logic [RecW-1:0]  rec_q, head_rec;
  logic             fifo_dropped, fifo_full, fifo_empty;

  assign first_pix = (pix_cnt_q == '0);
  assign differ    = (sample != level_q);
  assign run_inc   = run_q + RunW'(1);
  assign accept    = pix_take && !first_pix && differ && (run_inc == RunAccept);
  assign acc_pos   = (run_q == '0) ? pix_cnt_q : cand_pos_q;
  assign cnt_next  = (accept && !(&line_cnt_q)) ? line_cnt_q + CNT_W'(1) : line_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_q    <= '0;
      level_q      <= 1'b0;
      run_q        <= '0;
      cand_pos_q   <= '0;
      line_cnt_q   <= '0;
      line_edges_q <= '0;
      push_q       <= 1'b0;
      rec_q        <= '0;
      line_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (!en) begin
      pix_cnt_q   <= '0;
      run_q       <= '0;
      line_cnt_q  <= '0;
      push_q      <= 1'b0;
      line_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      line_done_q <= last_pix;
      push_q      <= accept;
      if (accept) rec_q <= RecW'(edge_pack(sample, edge_pos_t'(acc_pos), PIX_W));
      if (fifo_dropped) overflow_q <= 1'b1;
      if (line_start) begin
        pix_cnt_q  <= '0;
        run_q      <= '0;
        line_cnt_q <= '0;
      end else if (pix_take) begin
        pix_cnt_q  <= pix_cnt_q + PIX_W'(1);
        line_cnt_q <= last_pix ? '0 : cnt_next;
        if (last_pix) line_edges_q <= cnt_next;
        if (first_pix || accept) begin
          level_q <= sample;
          run_q   <= '0;
        end else if (!differ) begin
          run_q <= '0;
        end else begin
          if (run_q == '0) cand_pos_q <= pix_cnt_q;
          run_q <= run_inc;
        end
      end
    end
  end

  ccd_edge_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (RecW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (!en),
    .push      (push_q),
    .push_data (rec_q),
    .dropped   (fifo_dropped),
    .out_valid (edge_valid),
    .out_ready (edge_ready),
    .out_data  (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head fields read as zero while the FIFO is empty.
  assign edge_pos   = edge_valid ? PIX_W'(edge_pos_of(edge_rec_t'(head_rec), PIX_W)) : '0;
  assign edge_pol   = edge_valid && edge_pol_of(edge_rec_t'(head_rec), PIX_W);
  assign line_done  = line_done_q;
  assign line_edges = line_edges_q;
  assign overflow   = overflow_q;

  logic unused_flags;
  assign unused_flags = fifo_full ^ fifo_empty;

endmodule

// File: tb/tb_ccd_edge_reader.sv
// Directed bench: two 16-pixel readers (MIN_RUN 2 and 1) share stimulus; a 24-pixel
// reader with its own enable/ready covers FIFO overflow and enable drop.
module tb_ccd_edge_reader;
  import ccd_pkg::*;

  logic clk = 1'b0;
  logic rst, en_a, en_w, sh, ccd, din, rdy_a, rdy_w;
  logic [4:0] pos_a, pos_b, pos_w;
  logic       pol_a, pol_b, pol_w, val_a, val_b, val_w;
  logic       done_a, done_b, done_w, ovf_a, ovf_b, ovf_w;
  logic [5:0] edges_a, edges_b, edges_w;

  int n_assert = 0;
  int n_fail   = 0;
  int ndone_a  = 0;
  int ndone_w  = 0;
  int s0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done_a) ndone_a <= ndone_a + 1;
    if (done_w) ndone_w <= ndone_w + 1;
  end

  ccd_edge_reader #(.PIX_W(5), .NUM_PIX(16), .MIN_RUN(2), .FIFO_DEPTH(8), .CNT_W(6)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .sh_pulse(sh), .ccd_pulse(ccd), .data_in(din),
    .edge_pos(pos_a), .edge_pol(pol_a), .edge_valid(val_a), .edge_ready(rdy_a),
    .line_done(done_a), .line_edges(edges_a), .overflow(ovf_a));

  ccd_edge_reader #(.PIX_W(5), .NUM_PIX(16), .MIN_RUN(1), .FIFO_DEPTH(8), .CNT_W(6)) dut_b (
    .clk(clk), .rst(rst), .en(en_a), .sh_pulse(sh), .ccd_pulse(ccd), .data_in(din),
    .edge_pos(pos_b), .edge_pol(pol_b), .edge_valid(val_b), .edge_ready(rdy_a),
    .line_done(done_b), .line_edges(edges_b), .overflow(ovf_b));

  ccd_edge_reader #(.PIX_W(5), .NUM_PIX(24), .MIN_RUN(2), .FIFO_DEPTH(8), .CNT_W(6)) dut_w (
    .clk(clk), .rst(rst), .en(en_w), .sh_pulse(sh), .ccd_pulse(ccd), .data_in(din),
    .edge_pos(pos_w), .edge_pol(pol_w), .edge_valid(val_w), .edge_ready(rdy_w),
    .line_done(done_w), .line_edges(edges_w), .overflow(ovf_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sh_pulse_t;
    sh = 1'b1; tick(4);
    sh = 1'b0; tick(4);
  endtask

  task automatic pixels(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      din = bits[i[4:0]];
      tick(3);
      ccd = 1'b1; tick(3);
      ccd = 1'b0; tick(2);
    end
  endtask

  task automatic pop_ab(input string tag, input logic use_a, input logic use_b,
                        input logic pol, input int pos);
    if (use_a) begin
      chk({tag, ".a.valid"}, 32'(val_a), 32'd1);
      chk({tag, ".a.pol"},   32'(pol_a), 32'(pol));
      chk({tag, ".a.pos"},   32'(pos_a), 32'(pos));
    end
    if (use_b) begin
      chk({tag, ".b.valid"}, 32'(val_b), 32'd1);
      chk({tag, ".b.pol"},   32'(pol_b), 32'(pol));
      chk({tag, ".b.pos"},   32'(pos_b), 32'(pos));
    end
    rdy_a = 1'b1; tick(1); rdy_a = 1'b0;
  endtask

  task automatic pop_w(input string tag, input logic pol, input int pos);
    chk({tag, ".valid"}, 32'(val_w), 32'd1);
    chk({tag, ".pol"},   32'(pol_w), 32'(pol));
    chk({tag, ".pos"},   32'(pos_w), 32'(pos));
    rdy_w = 1'b1; tick(1); rdy_w = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en_a = 1'b0; en_w = 1'b0; sh = 1'b0; ccd = 1'b0; din = 1'b0;
    rdy_a = 1'b0; rdy_w = 1'b0;
    tick(2);
    chk("rst.valid", 32'(val_a), 32'd0);
    chk("rst.pos",   32'(pos_a), 32'd0);
    chk("rst.pol",   32'(pol_a), 32'd0);
    chk("rst.done",  32'(done_a), 32'd0);
    chk("rst.edges", 32'(edges_a), 32'd0);
    chk("rst.ovf",   32'(ovf_a), 32'd0);
    rst = 1'b0; en_a = 1'b1; tick(3);

    // Low 0-4, high from 5: one rising edge at 5
    s0 = ndone_a;
    sh_pulse_t; pixels(32'h0000_FFE0, 16); tick(4);
    chk("t1.done",    32'(ndone_a - s0), 32'd1);
    chk("t1.edges.a", 32'(edges_a), 32'd1);
    chk("t1.edges.b", 32'(edges_b), 32'd1);
    pop_ab("t1.rec", 1'b1, 1'b1, 1'b1, 5);
    chk("t1.empty.a", 32'(val_a), 32'd0);
    chk("t1.empty.b", 32'(val_b), 32'd0);

    // Single-pixel glitch at 7: filtered with MIN_RUN 2, two edges with MIN_RUN 1
    sh_pulse_t; pixels(32'h0000_0080, 16); tick(4);
    chk("t2.edges.a", 32'(edges_a), 32'd0);
    chk("t2.empty.a", 32'(val_a), 32'd0);
    chk("t2.edges.b", 32'(edges_b), 32'd2);
    pop_ab("t2.r0", 1'b0, 1'b1, 1'b1, 7);
    pop_ab("t2.r1", 1'b0, 1'b1, 1'b0, 8);
    chk("t2.empty.b", 32'(val_b), 32'd0);

    // High 0-3 then low: pixel 0 only sets the level, falling edge at 4
    sh_pulse_t; pixels(32'h0000_000F, 16); tick(4);
    chk("t3.edges.a", 32'(edges_a), 32'd1);
    pop_ab("t3.rec", 1'b1, 1'b1, 1'b0, 4);
    chk("t3.empty.a", 32'(val_a), 32'd0);

    // Abort at pixel 9 by a new sh; edge of the aborted line stays queued
    s0 = ndone_a;
    sh_pulse_t; pixels(32'h0000_01F8, 9);
    sh_pulse_t; pixels(32'h0000_F800, 16); tick(4);
    chk("t5.done",    32'(ndone_a - s0), 32'd1);
    chk("t5.edges.a", 32'(edges_a), 32'd1);
    chk("t5.edges.b", 32'(edges_b), 32'd1);
    pop_ab("t5.r0", 1'b1, 1'b1, 1'b1, 3);
    pop_ab("t5.r1", 1'b1, 1'b1, 1'b1, 11);
    chk("t5.empty.a", 32'(val_a), 32'd0);

    // 10 alternating 2-pixel runs into an 8-deep FIFO while stalled
    en_a = 1'b0; en_w = 1'b1; tick(3);
    s0 = ndone_w;
    sh_pulse_t; pixels(32'h000C_CCCC, 24); tick(4);
    chk("t4.done",  32'(ndone_w - s0), 32'd1);
    chk("t4.edges", 32'(edges_w), 32'd10);
    chk("t4.ovf",   32'(ovf_w), 32'd1);
    chk("t4.head.pos", 32'(pos_w), 32'd2);
    tick(3);
    chk("t4.stall.pos",   32'(pos_w), 32'd2);
    chk("t4.stall.pol",   32'(pol_w), 32'd1);
    chk("t4.stall.valid", 32'(val_w), 32'd1);
    for (int k = 0; k < 8; k++) pop_w("t4.drain", (k % 2) == 0, 2 + 2 * k);
    chk("t4.empty",     32'(val_w), 32'd0);
    chk("t4.ovf.stick", 32'(ovf_w), 32'd1);

    // Enable drop mid-line with a queued record
    sh_pulse_t; pixels(32'h0000_0078, 7); tick(2);
    chk("t6.valid.pre", 32'(val_w), 32'd1);
    chk("t6.pos.pre",   32'(pos_w), 32'd3);
    en_w = 1'b0; tick(1);
    chk("t6.valid", 32'(val_w), 32'd0);
    chk("t6.ovf",   32'(ovf_w), 32'd0);
    chk("t6.state", 32'(dut_w.state_q), 32'(StIdle));

    // Asynchronous reset mid-line
    en_a = 1'b1; tick(3);
    chk("t7.edges.pre", 32'(edges_a), 32'd1);
    sh_pulse_t; pixels(32'h0000_0078, 7); tick(2);
    chk("t7.valid.pre", 32'(val_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7.valid", 32'(val_a), 32'd0);
    chk("t7.pos",   32'(pos_a), 32'd0);
    chk("t7.pol",   32'(pol_a), 32'd0);
    chk("t7.edges", 32'(edges_a), 32'd0);
    chk("t7.ovf",   32'(ovf_a), 32'd0);
    chk("t7.done",  32'(done_a), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
